// File: rtl/mire_writer_if.sv
// Wishbone bus bundle between the test-pattern writer and the SDRAM arbiter.
// The clock and synchronous active-high reset enter as plain ports of the
// interface so that both sides of the bus see the same clock domain.
interface mire_writer_if (
   input logic clk,
   input logic rst
);

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;

   // The pattern writer drives the request side and listens for ack.
   modport master (
      input  clk, rst, ack,
      output cyc, stb, we, adr, dat_ms, sel, cti, bte
   );

   // The arbiter / SDRAM side answers each strobe with ack.
   modport slave (
      input  clk, rst, cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output ack
   );

endinterface

// File: rtl/mire_writer.sv
// Wishbone write master that paints a grid test pattern into the SDRAM
// framebuffer, row-major at byte address (x + y*HDISP)*4. It releases the bus
// every BURST_LEN writes for YIELD_CYCLES clocks so the VGA reader can be
// granted by the arbiter.
// Build option: define MIRE_LOOP_EN to repaint the frame forever instead of
// stopping in DONE after one frame.
module mire_writer #(
   parameter int HDISP        = 800,
   parameter int VDISP        = 480,
   parameter int BURST_LEN    = 64,
   parameter int YIELD_CYCLES = 16
) (
   mire_writer_if.master wshb_ifm,
   output logic          done
);

   localparam int XW = (HDISP        > 1) ? $clog2(HDISP)        : 1;
   localparam int YW = (VDISP        > 1) ? $clog2(VDISP)        : 1;
   localparam int BW = (BURST_LEN    > 1) ? $clog2(BURST_LEN)    : 1;
   localparam int CW = (YIELD_CYCLES > 1) ? $clog2(YIELD_CYCLES) : 1;

   localparam logic [XW-1:0] X_LAST     = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(VDISP - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
   localparam logic [CW-1:0] YIELD_LAST = CW'(YIELD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      YIELD,
      DONE
   } StateT;

   StateT          state;
   logic [XW-1:0]  pixelX;
   logic [YW-1:0]  pixelY;
   logic [BW-1:0]  burstCnt;
   logic [CW-1:0]  yieldCnt;
   logic           stbReg;
   logic           lastX;
   logic           lastY;
   logic           isWhite;
   logic [31:0]    pixIndex;

   assign lastX = (pixelX == X_LAST);
   assign lastY = (pixelY == Y_LAST);

   // cyc and stb are the same registered bit; the remaining qualifiers are
   // fixed because this master only ever issues classic single writes.
   assign wshb_ifm.cyc = stbReg;
   assign wshb_ifm.stb = stbReg;
   assign wshb_ifm.we  = 1'b1;
   assign wshb_ifm.sel = 4'b1111;
   assign wshb_ifm.cti = 3'b000;
   assign wshb_ifm.bte = 2'b00;

   // Address and pixel colour depend only on the registered pixel position,
   // so they stay frozen for as long as the slave withholds ack. The grid is
   // a white line every 16 pixels plus a white border on the right and bottom.
   always_comb begin
      pixIndex = 32'(pixelX) + 32'(pixelY) * 32'(HDISP);
      isWhite  = ((32'(pixelX) & 32'hF) == 32'h0) ||
                 ((32'(pixelY) & 32'hF) == 32'h0) ||
                 lastX || lastY;
      wshb_ifm.adr    = pixIndex << 2;
      wshb_ifm.dat_ms = isWhite ? 32'h00FF_FFFF : 32'h0000_0000;
   end

   // Main sequencer: walks the frame one acked write at a time, hands the bus
   // back after every full burst, and either stops in DONE or wraps to the
   // top of the frame. The last pixel always closes its tenure, so a frame is
   // never split across a wrap.
   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst) begin
         state    <= IDLE;
         pixelX   <= '0;
         pixelY   <= '0;
         burstCnt <= '0;
         yieldCnt <= '0;
         stbReg   <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state  <= WRITE;
               stbReg <= 1'b1;
            end
            WRITE: begin
               if (wshb_ifm.ack) begin
                  if (lastX) begin
                     pixelX <= '0;
                     pixelY <= pixelY + 1'b1;
                  end else begin
                     pixelX <= pixelX + 1'b1;
                  end
                  burstCnt <= burstCnt + 1'b1;
                  if (lastX && lastY) begin
`ifdef MIRE_LOOP_EN
                     pixelX   <= '0;
                     pixelY   <= '0;
                     burstCnt <= '0;
                     yieldCnt <= '0;
                     stbReg   <= 1'b0;
                     state    <= YIELD;
`else
                     stbReg   <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
`endif
                  end else if (burstCnt == BURST_LAST) begin
                     burstCnt <= '0;
                     yieldCnt <= '0;
                     stbReg   <= 1'b0;
                     state    <= YIELD;
                  end
               end
            end
            YIELD: begin
               if (yieldCnt == YIELD_LAST) begin
                  stbReg <= 1'b1;
                  state  <= WRITE;
               end else begin
                  yieldCnt <= yieldCnt + 1'b1;
               end
            end
            DONE: begin
               stbReg <= 1'b0;
               done   <= 1'b1;
            end
            default: begin
               stbReg <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
